lsu: RTL and testbench
======================

# lsu

Load/store unit between the RV32I core's memory-stage signals and a variable-latency data memory; the next step toward the multicycle core. Accepts a load or store (address, funct3, rs2 data), checks alignment, generates word address, byte strobes and lane-replicated write data, and runs a req/ack handshake with memory. Stalls the core until the access completes, then returns the sign- or zero-extended load result.

## Interface
- MAX_WAIT, 15: maximum cycles spent in ACCESS waiting for MemAck before an access fault is raised.
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- MemRead  in  1  core requests a load.
- MemWrite  in  1  core requests a store; wins if both MemRead and MemWrite are high.
- Funct3  in  3  instruction funct3 (width and sign).
- Adr  in  32  byte address (ALUResult).
- WriteData  in  32  rs2 value, unshifted.
- Stall  out  1  core must hold PC and request inputs.
- Done  out  1  one-cycle pulse at access completion or error.
- LoadResult  out  32  extended load data; valid only while Done=1, 0 otherwise.
- Misaligned  out  1  with Done: address misaligned for the access width.
- AccessFault  out  1  with Done: illegal funct3 or MemAck timeout.
- MemReq  out  1  memory request.
- MemWe  out  1  1 = write.
- MemAdr  out  32  {Adr[31:2], 2'b00}.
- MemWdata  out  32  lane-replicated store data.
- MemBe  out  4  byte strobes.
- MemAck  in  1  memory completion; MemRdata sampled in the same cycle.
- MemRdata  in  32  read word.

## Operation
- States: IDLE, ACCESS, RESP, ERR.
- IDLE: if MemRead|MemWrite, latch Adr, Funct3, WriteData and the direction.
  - Illegal funct3 -> ERR. Legal loads: 000, 001, 010, 100, 101. Legal stores: 000, 001, 010.
  - Misaligned -> ERR. Half-word with Adr[0]=1; word with Adr[1:0]!=0.
  - Otherwise -> ACCESS.
- ACCESS: MemReq=1. MemAdr, MemWe, MemBe and MemWdata are driven from latched values and held stable until MemAck.
  - MemAck=1 -> RESP, latching MemRdata.
  - Wait counter reaches MAX_WAIT with no ack -> ERR with AccessFault.
- RESP: Done=1, LoadResult driven (0 for stores) -> IDLE.
- ERR: Done=1, Misaligned or AccessFault=1, LoadResult=0, no memory request issued -> IDLE.
- Store strobes:
  - sb: MemBe = 4'b0001 << Adr[1:0].
  - sh: MemBe = 4'b0011 << {Adr[1],1'b0}.
  - sw: MemBe = 4'b1111.
- Store data:
  - sb: MemWdata = {4{WriteData[7:0]}}.
  - sh: MemWdata = {2{WriteData[15:0]}}.
  - sw: MemWdata = WriteData.
- Loads: MemBe=4'b1111.
  - Byte selected by latched Adr[1:0]; half-word selected by Adr[1].
  - lb and lh sign-extend; lbu and lhu zero-extend.
- Stall = (state==IDLE & (MemRead|MemWrite)) | state==ACCESS. Stall is 0 in RESP and ERR, so the core advances on the Done edge.
- The request inputs are ignored in RESP and ERR. This prevents double capture.

## Timing
- Reset values:
  - state IDLE, wait counter 0.
  - MemReq, MemWe, Done, Misaligned, AccessFault = 0.
  - MemBe = 0, LoadResult = 0, MemAdr = 0, MemWdata = 0.
- Request presented in cycle 0: MemReq goes high in cycle 1.
- Ack in cycle 1+k: Done in cycle 2+k. Minimum request-to-Done latency is 2 cycles.
- Error path: Done in cycle 1. Timeout: Done in cycle MAX_WAIT+2.
- Reset asserted mid-ACCESS: MemReq drops on the next edge. The memory tolerates the abandoned request.
- MemAck outside ACCESS is ignored.

## Structure
- lsu_pkg holds:
  - the state enum;
  - funct3 constants (F3_B, F3_H, F3_W, F3_BU, F3_HU);
  - the wait-counter width, $clog2(MAX_WAIT+1).
- Sub-module lsu_align is combinational. It takes funct3, Adr[1:0], WriteData and the read word. It returns MemBe, MemWdata and the extended load value.
- The FSM, latches and counter stay in lsu.

## Test plan
- sb: WriteData=0x000000A5, Adr=0x103, ack in ACCESS cycle 1. Required: MemAdr=0x100, MemBe=4'b1000, MemWdata=0xA5A5A5A5, Done 2 cycles after the request.
- lb vs lbu: Adr=0x102, MemRdata=0x12F45678, ack after 3 wait cycles. Required: lb LoadResult=0xFFFFFFF4 and lbu LoadResult=0x000000F4, each with Done in cycle 5.
- lh: Adr=0x202, MemRdata=0x8001_7FFF. Required: LoadResult=0xFFFF8001.
- sw: WriteData=0xDEADBEEF, Adr=0x64. Required: MemBe=4'b1111, MemWdata=0xDEADBEEF.
- Misaligned: lw at Adr=0x66 and sh at Adr=0x65. Required: MemReq never asserted, Done=Misaligned=1 in cycle 1, LoadResult=0.
- Fault and reset:
  - MemAck held 0: AccessFault and Done in cycle MAX_WAIT+2 (17).
  - Funct3=3'b011 load: AccessFault in cycle 1.
  - Reset asserted in ACCESS cycle 2: state IDLE and MemReq=0 the next cycle.

Source files
------------

// File: rtl/lsu_pkg.sv
// lsu_pkg: shared constants and helpers for the load/store unit.
//   - FSM state encoding (IDLE, ACCESS, RESP, ERR)
//   - RV32I load/store funct3 codes
//   - wait-counter width for the MemAck timeout
//   - legality and alignment helpers used when a request is accepted
package lsu_pkg;

    localparam int MAX_WAIT_DEF = 15;
    localparam int WAIT_W       = $clog2(MAX_WAIT_DEF + 1);

    typedef logic [1:0] state_t;
    localparam state_t S_IDLE   = 2'd0;
    localparam state_t S_ACCESS = 2'd1;
    localparam state_t S_RESP   = 2'd2;
    localparam state_t S_ERR    = 2'd3;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    // Unsigned widths only exist for loads.
    function automatic logic f3_legal(input logic [2:0] f3, input logic store);
        case (f3)
            F3_B, F3_H, F3_W: return 1'b1;
            F3_BU, F3_HU:     return !store;
            default:          return 1'b0;
        endcase
    endfunction

    // funct3[1:0] encodes the access width for every legal code.
    function automatic logic adr_misaligned(input logic [2:0] f3, input logic [1:0] adr_lo);
        case (f3[1:0])
            2'b01:   return adr_lo[0];
            2'b10:   return adr_lo != 2'b00;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/lsu_align.sv
// lsu_align: combinational lane logic for the load/store unit.
//   funct3     in  3   access width/sign
//   adr_lo     in  2   byte offset within the word
//   store      in  1   1 = store, 0 = load
//   wdata      in  32  unshifted store data
//   rdata      in  32  word read from memory
//   mem_be     out 4   byte strobes (all ones for loads)
//   mem_wdata  out 32  lane-replicated store data
//   load_value out 32  selected and extended load data
module lsu_align
    import lsu_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  adr_lo,
    input  logic        store,
    input  logic [31:0] wdata,
    input  logic [31:0] rdata,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    output logic [31:0] load_value
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        mem_be    = 4'b1111;
        mem_wdata = wdata;
        if (store) begin
            case (funct3[1:0])
                2'b00: begin
                    mem_be    = 4'b0001 << adr_lo;
                    mem_wdata = {4{wdata[7:0]}};
                end
                2'b01: begin
                    mem_be    = 4'b0011 << {adr_lo[1], 1'b0};
                    mem_wdata = {2{wdata[15:0]}};
                end
                default: begin
                    mem_be    = 4'b1111;
                    mem_wdata = wdata;
                end
            endcase
        end
    end

    always_comb begin
        case (adr_lo)
            2'd0:    byte_sel = rdata[7:0];
            2'd1:    byte_sel = rdata[15:8];
            2'd2:    byte_sel = rdata[23:16];
            default: byte_sel = rdata[31:24];
        endcase
        half_sel = adr_lo[1] ? rdata[31:16] : rdata[15:0];
    end

    always_comb begin
        case (funct3)
            F3_B:    load_value = {{24{byte_sel[7]}}, byte_sel};
            F3_H:    load_value = {{16{half_sel[15]}}, half_sel};
            F3_W:    load_value = rdata;
            F3_BU:   load_value = {24'd0, byte_sel};
            F3_HU:   load_value = {16'd0, half_sel};
            default: load_value = 32'd0;
        endcase
    end

endmodule

// File: rtl/lsu.sv
// lsu: load/store unit between the core memory stage and a variable-latency
// data memory with a req/ack handshake.
//   clk, reset        clock, synchronous active-high reset
//   MemRead/MemWrite  core request (store wins when both are high)
//   Funct3, Adr       access width/sign and byte address
//   WriteData         rs2 value, unshifted
//   Stall             core holds PC and request while high
//   Done              one-cycle completion/error pulse
//   LoadResult        extended load data, valid only with Done
//   Misaligned        with Done: address not aligned to the width
//   AccessFault       with Done: illegal funct3 or MemAck timeout
//   MemReq/MemWe      memory request and direction
//   MemAdr/MemWdata   word address and lane-replicated store data
//   MemBe             byte strobes
//   MemAck/MemRdata   memory completion and read word (same cycle)
//
// state  | meaning
// IDLE   | waiting for MemRead/MemWrite; request checked and latched
// ACCESS | MemReq high, waiting for MemAck or timeout
// RESP   | Done with LoadResult (0 for stores)
// ERR    | Done with Misaligned or AccessFault, no memory access made
module lsu
    import lsu_pkg::*;
#(
    parameter int MAX_WAIT = MAX_WAIT_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic [2:0]  Funct3,
    input  logic [31:0] Adr,
    input  logic [31:0] WriteData,
    output logic        Stall,
    output logic        Done,
    output logic [31:0] LoadResult,
    output logic        Misaligned,
    output logic        AccessFault,
    output logic        MemReq,
    output logic        MemWe,
    output logic [31:0] MemAdr,
    output logic [31:0] MemWdata,
    output logic [3:0]  MemBe,
    input  logic        MemAck,
    input  logic [31:0] MemRdata
);

    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MAX_WAIT);

    state_t              state;
    logic [WAIT_W-1:0]   wait_cnt;
    logic [31:0]         adr_q;
    logic [2:0]          f3_q;
    logic [31:0]         wdata_q;
    logic [31:0]         rdata_q;
    logic                store_q;
    logic                mis_q;
    logic                fault_q;

    logic                req;
    logic                req_store;
    logic                req_illegal;
    logic                req_mis;
    logic [3:0]          be;
    logic [31:0]         wdata_lane;
    logic [31:0]         load_value;

    assign req         = MemRead | MemWrite;
    assign req_store   = MemWrite;
    assign req_illegal = !f3_legal(Funct3, req_store);
    assign req_mis     = adr_misaligned(Funct3, Adr[1:0]);

    // Aligner works on latched values only, so the bus stays stable in ACCESS.
    lsu_align u_align (
        .funct3     (f3_q),
        .adr_lo     (adr_q[1:0]),
        .store      (store_q),
        .wdata      (wdata_q),
        .rdata      (rdata_q),
        .mem_be     (be),
        .mem_wdata  (wdata_lane),
        .load_value (load_value)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= S_IDLE;
            wait_cnt <= '0;
            adr_q    <= '0;
            f3_q     <= '0;
            wdata_q  <= '0;
            rdata_q  <= '0;
            store_q  <= 1'b0;
            mis_q    <= 1'b0;
            fault_q  <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (req) begin
                        adr_q    <= Adr;
                        f3_q     <= Funct3;
                        wdata_q  <= WriteData;
                        store_q  <= req_store;
                        wait_cnt <= '0;
                        // Illegal funct3 is reported in preference to misalignment.
                        fault_q  <= req_illegal;
                        mis_q    <= !req_illegal && req_mis;
                        state    <= (req_illegal || req_mis) ? S_ERR : S_ACCESS;
                    end
                end
                S_ACCESS: begin
                    if (MemAck) begin
                        rdata_q <= MemRdata;
                        state   <= S_RESP;
                    end else if (wait_cnt == WAIT_LAST) begin
                        fault_q <= 1'b1;
                        mis_q   <= 1'b0;
                        state   <= S_ERR;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                S_RESP:  state <= S_IDLE;
                S_ERR:   state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    assign Stall       = (state == S_IDLE && req) || state == S_ACCESS;
    assign Done        = state == S_RESP || state == S_ERR;
    assign LoadResult  = (state == S_RESP && !store_q) ? load_value : 32'd0;
    assign Misaligned  = state == S_ERR && mis_q;
    assign AccessFault = state == S_ERR && fault_q;

    assign MemReq   = state == S_ACCESS;
    assign MemWe    = state == S_ACCESS && store_q;
    assign MemAdr   = (state == S_ACCESS) ? {adr_q[31:2], 2'b00} : 32'd0;
    assign MemWdata = (state == S_ACCESS) ? wdata_lane : 32'd0;
    assign MemBe    = (state == S_ACCESS) ? be : 4'd0;

endmodule

// File: tb/tb_lsu.sv
// tb_lsu: scoreboard bench for lsu. Each access pushes its expected completion
// (cycle, LoadResult, flags) to a queue; a monitor pops and compares on Done.
module tb_lsu;
    import lsu_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        MemRead, MemWrite;
    logic [2:0]  Funct3;
    logic [31:0] Adr, WriteData;
    logic        Stall, Done, Misaligned, AccessFault;
    logic [31:0] LoadResult;
    logic        MemReq, MemWe;
    logic [31:0] MemAdr, MemWdata;
    logic [3:0]  MemBe;
    logic        MemAck;
    logic [31:0] MemRdata;

    lsu #(.MAX_WAIT(15)) dut (
        .clk(clk), .reset(reset), .MemRead(MemRead), .MemWrite(MemWrite),
        .Funct3(Funct3), .Adr(Adr), .WriteData(WriteData), .Stall(Stall),
        .Done(Done), .LoadResult(LoadResult), .Misaligned(Misaligned),
        .AccessFault(AccessFault), .MemReq(MemReq), .MemWe(MemWe),
        .MemAdr(MemAdr), .MemWdata(MemWdata), .MemBe(MemBe),
        .MemAck(MemAck), .MemRdata(MemRdata)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    typedef struct {
        int          cyc;
        logic [31:0] ld;
        logic        mis;
        logic        flt;
    } exp_t;
    exp_t exp_q[$];

    always @(negedge clk) begin
        if (!reset && Done) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_done", 32'(Done), 32'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("done_cycle", 32'(cyc), 32'(e.cyc));
                chk("load_result", LoadResult, e.ld);
                chk("misaligned", 32'(Misaligned), 32'(e.mis));
                chk("access_fault", 32'(AccessFault), 32'(e.flt));
            end
        end
    end

    // k: ack in ACCESS cycle 1+k (k<0 = never ack); lat: expected Done cycle.
    task automatic access(input logic rd, input logic wr, input logic [2:0] f3,
                          input logic [31:0] adr, input logic [31:0] wd,
                          input logic [31:0] word, input int k, input int lat,
                          input logic exp_req, input logic [31:0] exp_ld,
                          input logic exp_mis, input logic exp_flt,
                          input logic [3:0] exp_be, input logic [31:0] exp_wd);
        int   c0;
        logic req_seen;
        logic done;
        exp_t e;
        @(posedge clk); #1;
        MemRead = rd; MemWrite = wr; Funct3 = f3; Adr = adr; WriteData = wd;
        MemRdata = word;
        c0 = cyc;
        e.cyc = c0 + lat; e.ld = exp_ld; e.mis = exp_mis; e.flt = exp_flt;
        exp_q.push_back(e);
        req_seen = 1'b0;
        done = 1'b0;
        for (int i = 0; i < 40 && !done; i++) begin
            @(negedge clk);
            if (i == 0) chk("stall_c0", 32'(Stall), 32'd1);
            if (MemReq && !req_seen) begin
                req_seen = 1'b1;
                chk("req_cycle", 32'(i), 32'd1);
                chk("mem_adr", MemAdr, {adr[31:2], 2'b00});
                chk("mem_we", 32'(MemWe), 32'(wr));
                chk("mem_be", 32'(MemBe), 32'(exp_be));
                chk("mem_wdata", MemWdata, exp_wd);
            end
            if (Done) done = 1'b1;
            @(posedge clk); #1;
            MemAck = (k >= 0) && (i + 1 == 1 + k) && !done;
            if (done) begin
                MemRead = 1'b0; MemWrite = 1'b0; MemAck = 1'b0;
            end
        end
        if (!done) begin
            chk("done_timeout", 32'd0, 32'd1);
            MemRead = 1'b0; MemWrite = 1'b0; MemAck = 1'b0;
        end
        chk("req_seen", 32'(req_seen), 32'(exp_req));
    endtask

    initial begin
        reset = 1'b1; MemRead = 1'b0; MemWrite = 1'b0; Funct3 = '0;
        Adr = '0; WriteData = '0; MemAck = 1'b0; MemRdata = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_memreq", 32'(MemReq), 32'd0);
        chk("rst_done", 32'(Done), 32'd0);
        chk("rst_be", 32'(MemBe), 32'd0);
        chk("rst_adr", MemAdr, 32'd0);
        chk("rst_wdata", MemWdata, 32'd0);
        chk("rst_ld", LoadResult, 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;

        // sb
        access(0, 1, F3_B, 32'h103, 32'h000000A5, 32'h0, 0, 2, 1, 32'h0, 0, 0, 4'b1000, 32'hA5A5A5A5);
        // lb / lbu, ack after 3 wait cycles
        access(1, 0, F3_B,  32'h102, 32'h0, 32'h12F45678, 3, 5, 1, 32'hFFFFFFF4, 0, 0, 4'b1111, 32'h0);
        access(1, 0, F3_BU, 32'h102, 32'h0, 32'h12F45678, 3, 5, 1, 32'h000000F4, 0, 0, 4'b1111, 32'h0);
        // lh / lhu
        access(1, 0, F3_H,  32'h202, 32'h0, 32'h80017FFF, 1, 3, 1, 32'hFFFF8001, 0, 0, 4'b1111, 32'h0);
        access(1, 0, F3_HU, 32'h200, 32'h0, 32'h80017FFF, 0, 2, 1, 32'h00007FFF, 0, 0, 4'b1111, 32'h0);
        // lw
        access(1, 0, F3_W, 32'h64, 32'h0, 32'hCAFEF00D, 2, 4, 1, 32'hCAFEF00D, 0, 0, 4'b1111, 32'h0);
        // sw, with MemRead also high (store wins)
        access(1, 1, F3_W, 32'h64, 32'hDEADBEEF, 32'h0, 0, 2, 1, 32'h0, 0, 0, 4'b1111, 32'hDEADBEEF);
        // sh upper half
        access(0, 1, F3_H, 32'h06, 32'h1234ABCD, 32'h0, 1, 3, 1, 32'h0, 0, 0, 4'b1100, 32'hABCDABCD);
        // misaligned lw / sh
        access(1, 0, F3_W, 32'h66, 32'h0, 32'h0, -1, 1, 0, 32'h0, 1, 0, 4'b0, 32'h0);
        access(0, 1, F3_H, 32'h65, 32'h0, 32'h0, -1, 1, 0, 32'h0, 1, 0, 4'b0, 32'h0);
        // illegal funct3: load 011, store 100
        access(1, 0, 3'b011, 32'h80, 32'h0, 32'h0, -1, 1, 0, 32'h0, 0, 1, 4'b0, 32'h0);
        access(0, 1, F3_BU,  32'h80, 32'h0, 32'h0, -1, 1, 0, 32'h0, 0, 1, 4'b0, 32'h0);
        // MemAck never arrives
        access(1, 0, F3_W, 32'h400, 32'h0, 32'h0, -1, 17, 1, 32'h0, 0, 1, 4'b1111, 32'h0);

        // stray MemAck while idle must not complete anything
        @(posedge clk); #1; MemAck = 1'b1; MemRdata = 32'h55555555;
        @(negedge clk); chk("idle_ack_req", 32'(MemReq), 32'd0);
        @(posedge clk); #1; MemAck = 1'b0;
        @(negedge clk); chk("idle_ack_done", 32'(Done), 32'd0);

        // reset during ACCESS cycle 2
        @(posedge clk); #1;
        MemRead = 1'b1; Funct3 = F3_W; Adr = 32'h300;
        @(posedge clk); #1;
        @(negedge clk); chk("rst_mid_req1", 32'(MemReq), 32'd1);
        @(posedge clk); #1;
        reset = 1'b1; MemRead = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        chk("rst_mid_req", 32'(MemReq), 32'd0);
        chk("rst_mid_stall", 32'(Stall), 32'd0);
        chk("rst_mid_done", 32'(Done), 32'd0);
        @(posedge clk); #1; reset = 1'b0;
        repeat (2) @(posedge clk);

        chk("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

endmodule
